// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: buffers bytes from the upstream write slave in a small
// circular FIFO and shifts each one out on tx as an 8N1 frame (start bit,
// 8 data bits LSB first, one stop bit). The line idles high.
module uart_tx_serializer #(
  parameter int DIV   = 868,  // clock cycles per bit time, >= 2
  parameter int DEPTH = 4     // FIFO entries, power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, bit_end, fifo_nonempty;

  // Handshake: a byte transfers on any rising edge where valid && ready.
  // ready depends only on the current level (no look-ahead at a same-cycle
  // pop); valid while !ready is simply ignored and the byte is not written.
  assign ready         = (level != LVL_FULL);
  assign push          = valid && ready;
  assign fifo_nonempty = (level != '0);
  assign bit_end       = (baud == BAUD_LAST);
  assign busy          = (state != IDLE);

  // FIFO storage; entries need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves level alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Frame state register; reset drives the line high immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next-state logic: bit timing, shifting and FIFO pops at frame boundaries.
  always_comb begin
    state_n   = state;
    baud_n    = bit_end ? '0 : baud + BW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_n      = shift[0];
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx != 3'd7) begin
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end else begin
            tx_n    = 1'b1;
            state_n = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (fifo_nonempty) begin
            // Chain straight into the next start bit with no idle gap.
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
